// File: rtl/mod_arith_unit_pkg.sv
// Shared types for the modular arithmetic datapath: operation codes and unit state.
package elliptic_curve_structs;

  typedef enum logic [1:0] {
    MOD_ADD  = 2'd0,
    MOD_SUB  = 2'd1,
    MOD_MUL  = 2'd2,
    MOD_RSVD = 2'd3
  } mod_op_t;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_MUL,
    MS_DONE
  } mod_state_t;

endpackage

// File: rtl/mod_arith_unit_if.sv
// Request/response bundle of mod_arith_unit: valid/ready in, valid/ready out.
interface mod_arith_unit_if #(
  parameter int unsigned WIDTH = 256
);
  import elliptic_curve_structs::*;

  logic             in_valid;
  logic             in_ready;
  mod_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] p;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, op, a, b, p, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, op, a, b, p, out_ready,
    output in_ready, out_valid, result, err
  );

endinterface

// File: rtl/mod_arith_unit_add_sub.sv
// Combinational a +/- b mod p for operands already reduced below p.
module mod_add_sub #(
  parameter int unsigned WIDTH = 256
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] p,
  input  logic             sub,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic [WIDTH:0] sum_red;
  logic [WIDTH:0] dif_fix;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign dif     = {1'b0, a} - {1'b0, b};
  assign sum_red = sum - {1'b0, p};
  // a < b: the borrow wraps modulo 2^(WIDTH+1) and adding p lands back in [0, p)
  assign dif_fix = dif + {1'b0, p};

  always_comb begin
    y = '0;
    if (sub) begin
      y = (a >= b) ? dif[WIDTH-1:0] : dif_fix[WIDTH-1:0];
    end else begin
      y = (sum >= {1'b0, p}) ? sum_red[WIDTH-1:0] : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mod_arith_unit.sv
// Sequential modular ADD/SUB/MUL engine with runtime modulus; one operation in flight.
module mod_arith_unit
  import elliptic_curve_structs::*;
#(
  parameter int unsigned WIDTH = 256
) (
  input logic             clk,
  input logic             rst_n,
  mod_arith_unit_if.slave bus
);

  localparam int unsigned   CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

  typedef logic [WIDTH-1:0] word_t;

  mod_state_t    state_q, state_d;
  word_t         a_q, b_q, p_q, acc_q, result_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;

  logic  accept, req_err, in_mul, as_sub;
  word_t as_a, as_b, as_p, as_y, mac_y, step;

  assign in_mul  = (state_q == MS_MUL);
  assign accept  = bus.in_valid && (state_q == MS_IDLE);
  assign req_err = (bus.op == MOD_RSVD) || (bus.p < WIDTH'(2)) ||
                   (bus.a >= bus.p) || (bus.b >= bus.p);

  // Outside MUL the shared adder serves the request; inside MUL it doubles acc (acc + acc).
  assign as_a   = in_mul ? acc_q : bus.a;
  assign as_b   = in_mul ? acc_q : bus.b;
  assign as_p   = in_mul ? p_q   : bus.p;
  assign as_sub = !in_mul && (bus.op == MOD_SUB);

  mod_add_sub #(.WIDTH(WIDTH)) u_add_sub (
    .a(as_a), .b(as_b), .p(as_p), .sub(as_sub), .y(as_y)
  );

  mod_add_sub #(.WIDTH(WIDTH)) u_mul_add (
    .a(as_y), .b(a_q), .p(p_q), .sub(1'b0), .y(mac_y)
  );

  assign step = b_q[cnt_q] ? mac_y : as_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MS_IDLE: if (accept) state_d = (req_err || bus.op != MOD_MUL) ? MS_DONE : MS_MUL;
      MS_MUL:  if (cnt_q == '0) state_d = MS_DONE;
      MS_DONE: if (bus.out_ready) state_d = MS_IDLE;
      default: state_d = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        MS_IDLE: if (accept) begin
          a_q   <= bus.a;
          b_q   <= bus.b;
          p_q   <= bus.p;
          acc_q <= '0;
          cnt_q <= CNT_TOP;
          err_q <= req_err;
          if (req_err)                result_q <= '0;
          else if (bus.op != MOD_MUL) result_q <= as_y;
        end
        MS_MUL: begin
          acc_q <= step;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) result_q <= step;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == MS_IDLE);
  assign bus.out_valid = (state_q == MS_DONE);
  assign bus.result    = result_q;
  assign bus.err       = err_q;

endmodule
